msg_chn_dispatch: RTL and testbench
===================================

Name: msg_chn_dispatch

Overview:
Upstream feeder for the per-channel data demultiplexer in msg_ta.
- Accepts a single valid/ready/last message stream.
- Decodes the destination channel from the first beat of each message and locks that channel for the whole message.
- Drives the demux data input and channel select from a one-stage output register, with a one-hot per-channel valid and per-channel ready back-pressure.
- Messages addressed to a nonexistent channel are consumed and dropped.

Parameters:
CHN_NUM, 6, number of downstream channels (≥2)
DWID, 256, beat width in bits
NUMWID, logb2(CHN_NUM) = 3, channel-select width (same logb2 rule as the demux)
SEL_LSB, 0, bit position of the channel-id field in the first beat; field is s_data[SEL_LSB +: NUMWID]

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_data  in  DWID  input beat
s_valid  in  1  input beat valid
s_last  in  1  last beat of message
s_ready  out  1  input accept
dout  out  DWID  registered beat, drives demux din
sel  out  NUMWID  registered channel select, drives demux sel
dout_last  out  1  registered last flag
chn_valid  out  CHN_NUM  one-hot valid; bit sel_q set when output register full
chn_ready  in  CHN_NUM  per-channel ready
bad_chn  out  1  one-cycle pulse when a message header carries channel id ≥ CHN_NUM

Behaviour:
- Reset values: s_ready=0, dout=0, sel=0, dout_last=0, chn_valid=0, bad_chn=0; FSM=IDLE.
- Transfer rules: s_fire = s_valid & s_ready; out_fire = out_vld & chn_ready[sel].
- chn_valid = out_vld ? (1<<sel) : 0. No other chn_valid bit may ever be set.
- Output register: latency 1 cycle from s_fire to chn_valid.
- dout, dout_last and sel stay stable while out_vld=1 and !out_fire.
- FSM IDLE:
  - s_ready = !out_vld. A new message cannot start until the previous message's last beat has left, so sel never changes under in-flight data.
  - On s_fire, ch = header field.
  - If ch < CHN_NUM: load the output register, sel←ch, then go to IDLE if s_last, else FWD.
  - If ch ≥ CHN_NUM: beat discarded, bad_chn=1 for one cycle, then go to IDLE if s_last, else DROP.
- FSM FWD:
  - s_ready = !out_vld | out_fire, so full throughput with a back-to-back beat on the same cycle as out_fire.
  - On s_fire, load the output register; if s_last, go to IDLE.
- FSM DROP: s_ready=1; beats discarded; on s_fire & s_last, go to IDLE.
- out_vld clears on out_fire without a simultaneous s_fire load.
- Single-beat message (s_last on header beat): valid, stays in IDLE.
- chn_ready of non-selected channels is ignored.
- CHN_NUM a power of two: DROP is unreachable and bad_chn is never asserted.
- Reset mid-message: all state is cleared asynchronously and the partial message is lost. The next accepted beat is treated as a header; upstream must be reset together with this block.
- No combinational path from s_valid to s_ready. s_ready depends on chn_ready via out_fire, which is intended.

Optional Feature:
MSG_DISPATCH_STAT_EN
- Defined: adds output pkt_cnt [32*CHN_NUM].
  - Per-channel counter i increments on out_fire & dout_last & sel==i, wrapping at 2^32.
- Defined: adds output drop_cnt [16], counting bad_chn pulses and saturating at 16'hFFFF.
- All counters reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then 3-beat message with header ch=2, all chn_ready=1 → chn_valid=6'b000100 for 3 consecutive cycles starting 1 cycle after first s_fire, sel=2 throughout, dout_last on 3rd beat.
- Same message with chn_ready[2] low for cycles 2-4 → dout/sel held, s_ready=0 while the register is full, no beat lost or duplicated; chn_ready[0]=1 has no effect.
- Back-to-back messages ch=1 then ch=4 → second header not accepted until ch=1 last beat has out_fire; sel switches 1→4 only with the new beat.
- Header ch=7 (CHN_NUM=6), 4-beat message → bad_chn pulses once, s_ready=1 for all 4 beats, chn_valid stays 0; next message ch=0 routes normally; drop_cnt=1 when STAT enabled.
- Single-beat messages ch=5 every cycle with chn_ready[5]=1 → one message accepted every other cycle (IDLE rule), pkt_cnt[5] equals the number delivered.
- rst_n asserted mid-message (beat 2 of 4) → all outputs 0 asynchronously; after release, the next beat is parsed as a header.

Source files
------------

// File: rtl/msg_chn_dispatch.sv
// Message stream to per-channel demux feeder with header channel lock.
// Optional MSG_DISPATCH_STAT_EN adds per-channel packet and drop counters.
module msg_chn_dispatch #(
  parameter int CHN_NUM = 6,
  parameter int DWID    = 256,
  parameter int NUMWID  = $clog2(CHN_NUM),
  parameter int SEL_LSB = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DWID-1:0]    s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [DWID-1:0]    dout,
  output logic [NUMWID-1:0]  sel,
  output logic               dout_last,
  output logic [CHN_NUM-1:0] chn_valid,
  input  logic [CHN_NUM-1:0] chn_ready,
  output logic               bad_chn
`ifdef MSG_DISPATCH_STAT_EN
  ,
  output logic [32*CHN_NUM-1:0] pkt_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_init;
  logic              r_vld;
  logic              r_bad;
  logic              r_last;
  logic [DWID-1:0]   r_dout;
  logic [NUMWID-1:0] r_sel;

  logic [NUMWID-1:0] w_ch;
  logic              w_ch_ok;
  logic              w_s_ready;
  logic              w_s_fire;
  logic              w_out_fire;
  logic              w_load;
  logic              w_drop;

  assign w_ch       = s_data[SEL_LSB +: NUMWID];
  assign w_ch_ok    = 32'(w_ch) < 32'(CHN_NUM);
  assign w_out_fire = r_vld & chn_ready[r_sel];
  assign w_s_fire   = s_valid & w_s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_s_fire && !s_last) begin
          w_next = w_ch_ok ? ST_FWD : ST_DROP;
        end
      end
      ST_FWD: begin
        if (w_s_fire && s_last) begin
          w_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_s_fire && s_last) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // A header waits for an empty register so sel never moves under data
  always_comb begin
    w_s_ready = 1'b0;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_s_ready = r_init & ~r_vld;
        w_load    = s_valid & w_s_ready & w_ch_ok;
        w_drop    = s_valid & w_s_ready & ~w_ch_ok;
      end
      ST_FWD: begin
        w_s_ready = ~r_vld | w_out_fire;
        w_load    = s_valid & w_s_ready;
      end
      ST_DROP: begin
        w_s_ready = 1'b1;
      end
      default: begin
        w_s_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init <= 1'b0;
      r_vld  <= 1'b0;
      r_bad  <= 1'b0;
      r_last <= 1'b0;
      r_dout <= '0;
      r_sel  <= '0;
    end else begin
      r_init <= 1'b1;
      r_bad  <= w_drop;
      if (w_load) begin
        r_vld  <= 1'b1;
        r_dout <= s_data;
        r_last <= s_last;
        if (r_state == ST_IDLE) begin
          r_sel <= w_ch;
        end
      end else if (w_out_fire) begin
        r_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    chn_valid = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      chn_valid[i] = r_vld & (int'(r_sel) == i);
    end
  end

  assign s_ready   = w_s_ready;
  assign dout      = r_dout;
  assign sel       = r_sel;
  assign dout_last = r_last;
  assign bad_chn   = r_bad;

`ifdef MSG_DISPATCH_STAT_EN
  logic [31:0] r_pkt [CHN_NUM];
  logic [15:0] r_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHN_NUM; i++) begin
        r_pkt[i] <= '0;
      end
      r_drop <= '0;
    end else begin
      for (int i = 0; i < CHN_NUM; i++) begin
        if (w_out_fire && r_last && int'(r_sel) == i) begin
          r_pkt[i] <= r_pkt[i] + 32'd1;
        end
      end
      if (r_bad && r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      pkt_cnt[32*i +: 32] = r_pkt[i];
    end
  end

  assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_msg_chn_dispatch.sv
// Testbench for msg_chn_dispatch: directed cycle table, reset
// sequence and randomized message traffic against a queue model.
module tb_msg_chn_dispatch;

  localparam int CHN  = 6;
  localparam int DW   = 256;
  localparam int NW   = 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] dout;
  logic [NW-1:0] sel;
  logic          dout_last;
  logic [CHN-1:0] chn_valid;
  logic [CHN-1:0] chn_ready;
  logic          bad_chn;
`ifdef MSG_DISPATCH_STAT_EN
  logic [32*CHN-1:0] pkt_cnt;
  logic [15:0]       drop_cnt;
`endif

  msg_chn_dispatch #(
    .CHN_NUM(CHN),
    .DWID(DW),
    .NUMWID(NW),
    .SEL_LSB(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .dout(dout),
    .sel(sel),
    .dout_last(dout_last),
    .chn_valid(chn_valid),
    .chn_ready(chn_ready),
    .bad_chn(bad_chn)
`ifdef MSG_DISPATCH_STAT_EN
    ,
    .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic [5:0]  rdy;
    logic        e_rdy;
    logic [5:0]  e_cv;
    logic [2:0]  e_sel;
    logic [15:0] e_do;
    logic        e_last;
    logic        e_bad;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [2:0]    ch;
  } beat_t;

  int n_chk = 0;
  int n_err = 0;
  int exp_pkt [CHN];
  int nbad;
  int nbadseen;
  vec_t  tv [34];
  beat_t sq [$];
  beat_t eq [$];

  function automatic vec_t mk(input logic v, input logic [15:0] d,
                              input logic l, input logic [5:0] rdy,
                              input logic er, input logic [5:0] ecv,
                              input logic [2:0] es, input logic [15:0] ed,
                              input logic el, input logic eb);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.rdy = rdy;
    t.e_rdy = er; t.e_cv = ecv; t.e_sel = es;
    t.e_do = ed; t.e_last = el; t.e_bad = eb;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_stats(input string nm, input int edrop);
`ifdef MSG_DISPATCH_STAT_EN
    for (int c = 0; c < CHN; c++) begin
      chk($sformatf("%s_pkt%0d", nm, c), pkt_cnt[32*c +: 32], exp_pkt[c]);
    end
    chk($sformatf("%s_drop", nm), drop_cnt, edrop);
`else
    n_chk += 0;
    if (edrop < 0) $display("negative drop expectation in %s", nm);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    chn_ready = '0;
    rst_n = 1'b0;
    for (int c = 0; c < CHN; c++) exp_pkt[c] = 0;

    tv[0]  = mk(1, 16'h0102, 0, 6'h3F, 1, 6'h00, 0, 16'h0000, 0, 0);
    tv[1]  = mk(1, 16'h0200, 0, 6'h3F, 1, 6'h04, 2, 16'h0102, 0, 0);
    tv[2]  = mk(1, 16'h0300, 1, 6'h3F, 1, 6'h04, 2, 16'h0200, 0, 0);
    tv[3]  = mk(0, 16'h0300, 1, 6'h3F, 0, 6'h04, 2, 16'h0300, 1, 0);
    tv[4]  = mk(0, 16'h0300, 1, 6'h3F, 1, 6'h00, 2, 16'h0300, 1, 0);
    tv[5]  = mk(1, 16'h1102, 0, 6'h01, 1, 6'h00, 2, 16'h0300, 1, 0);
    tv[6]  = mk(1, 16'h1200, 0, 6'h01, 0, 6'h04, 2, 16'h1102, 0, 0);
    tv[7]  = mk(1, 16'h1200, 0, 6'h01, 0, 6'h04, 2, 16'h1102, 0, 0);
    tv[8]  = mk(1, 16'h1200, 0, 6'h01, 0, 6'h04, 2, 16'h1102, 0, 0);
    tv[9]  = mk(1, 16'h1200, 0, 6'h3F, 1, 6'h04, 2, 16'h1102, 0, 0);
    tv[10] = mk(1, 16'h1300, 1, 6'h3F, 1, 6'h04, 2, 16'h1200, 0, 0);
    tv[11] = mk(0, 16'h1300, 1, 6'h3F, 0, 6'h04, 2, 16'h1300, 1, 0);
    tv[12] = mk(0, 16'h1300, 1, 6'h3F, 1, 6'h00, 2, 16'h1300, 1, 0);
    tv[13] = mk(1, 16'h2107, 0, 6'h3F, 1, 6'h00, 2, 16'h1300, 1, 0);
    tv[14] = mk(1, 16'h2200, 0, 6'h3F, 1, 6'h00, 2, 16'h1300, 1, 1);
    tv[15] = mk(1, 16'h2300, 0, 6'h3F, 1, 6'h00, 2, 16'h1300, 1, 0);
    tv[16] = mk(1, 16'h2400, 1, 6'h3F, 1, 6'h00, 2, 16'h1300, 1, 0);
    tv[17] = mk(1, 16'h3100, 1, 6'h3F, 1, 6'h00, 2, 16'h1300, 1, 0);
    tv[18] = mk(0, 16'h3100, 1, 6'h3F, 0, 6'h01, 0, 16'h3100, 1, 0);
    tv[19] = mk(0, 16'h3100, 1, 6'h3F, 1, 6'h00, 0, 16'h3100, 1, 0);
    tv[20] = mk(1, 16'h4105, 1, 6'h3F, 1, 6'h00, 0, 16'h3100, 1, 0);
    tv[21] = mk(1, 16'h4205, 1, 6'h3F, 0, 6'h20, 5, 16'h4105, 1, 0);
    tv[22] = mk(1, 16'h4205, 1, 6'h3F, 1, 6'h00, 5, 16'h4105, 1, 0);
    tv[23] = mk(1, 16'h4305, 1, 6'h3F, 0, 6'h20, 5, 16'h4205, 1, 0);
    tv[24] = mk(1, 16'h4305, 1, 6'h3F, 1, 6'h00, 5, 16'h4205, 1, 0);
    tv[25] = mk(0, 16'h4305, 1, 6'h3F, 0, 6'h20, 5, 16'h4305, 1, 0);
    tv[26] = mk(0, 16'h4305, 1, 6'h3F, 1, 6'h00, 5, 16'h4305, 1, 0);
    tv[27] = mk(1, 16'h5101, 0, 6'h3F, 1, 6'h00, 5, 16'h4305, 1, 0);
    tv[28] = mk(1, 16'h5200, 1, 6'h3F, 1, 6'h02, 1, 16'h5101, 0, 0);
    tv[29] = mk(1, 16'h6104, 1, 6'h3D, 0, 6'h02, 1, 16'h5200, 1, 0);
    tv[30] = mk(1, 16'h6104, 1, 6'h3F, 0, 6'h02, 1, 16'h5200, 1, 0);
    tv[31] = mk(1, 16'h6104, 1, 6'h3F, 1, 6'h00, 1, 16'h5200, 1, 0);
    tv[32] = mk(0, 16'h6104, 1, 6'h3F, 0, 6'h10, 4, 16'h6104, 1, 0);
    tv[33] = mk(0, 16'h6104, 1, 6'h3F, 1, 6'h00, 4, 16'h6104, 1, 0);

    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sel", sel, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_cv", chn_valid, 0);
    chk("rst_bad", bad_chn, 0);
    chk_stats("rst", 0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      @(posedge clk);
      #1;
      s_valid = tv[i].v;
      s_data = DW'(tv[i].d);
      s_last = tv[i].l;
      chn_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("tv%0d_srdy", i), s_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_cv", i), chn_valid, tv[i].e_cv);
      chk($sformatf("tv%0d_sel", i), sel, tv[i].e_sel);
      chk($sformatf("tv%0d_dout", i), dout, DW'(tv[i].e_do));
      chk($sformatf("tv%0d_last", i), dout_last, tv[i].e_last);
      chk($sformatf("tv%0d_bad", i), bad_chn, tv[i].e_bad);
    end
    exp_pkt[0] = 1; exp_pkt[1] = 1; exp_pkt[2] = 2;
    exp_pkt[3] = 0; exp_pkt[4] = 1; exp_pkt[5] = 3;
    chk_stats("tbl", 1);

    // reset lands while beat 2 of a 4-beat ch=3 message sits in the register
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = DW'(16'h8103); s_last = 1'b0; chn_ready = 6'h3F;
    @(posedge clk); #1;
    s_data = DW'(16'h8200);
    @(posedge clk); #1;
    s_data = DW'(16'h8300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_cv", chn_valid, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_sel", sel, 0);
    chk("mrst_last", dout_last, 0);
    chk("mrst_bad", bad_chn, 0);
    for (int c = 0; c < CHN; c++) exp_pkt[c] = 0;
    chk_stats("mrst", 0);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = DW'(16'h9105); s_last = 1'b1;
    @(negedge clk);
    chk("post_srdy", s_ready, 1);
    chk("post_cv0", chn_valid, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_cv", chn_valid, 6'h20);
    chk("post_sel", sel, 5);
    chk("post_dout", dout, DW'(16'h9105));
    chk("post_last", dout_last, 1);
    exp_pkt[5] = 1;

    nbad = 0;
    nbadseen = 0;
    for (int m = 0; m < 200; m++) begin
      int ch;
      int len;
      beat_t bt;
      ch = $urandom_range(0, 7);
      len = $urandom_range(1, 4);
      if (ch >= CHN) nbad++;
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < DW / 32; k++) bt.d[32*k +: 32] = $urandom;
        if (b == 0) bt.d[2:0] = 3'(ch);
        bt.l = (b == len - 1);
        bt.ch = 3'(ch);
        sq.push_back(bt);
        if (ch < CHN) eq.push_back(bt);
      end
    end

    for (int cyc = 0; cyc < 20000 && (sq.size() > 0 || eq.size() > 0); cyc++) begin
      @(posedge clk); #1;
      if (sq.size() > 0) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data = sq[0].d;
        s_last = sq[0].l;
      end else begin
        s_valid = 1'b0;
      end
      chn_ready = 6'($urandom) | 6'($urandom);
      @(negedge clk);
      if (bad_chn) nbadseen++;
      if (chn_valid != 0) begin
        if (eq.size() == 0) begin
          chk("rnd_extra", chn_valid, 0);
        end else begin
          chk("rnd_cv", chn_valid, 6'(1) << eq[0].ch);
          chk("rnd_sel", sel, eq[0].ch);
          chk("rnd_dout", dout, eq[0].d);
          chk("rnd_last", dout_last, eq[0].l);
          if ((chn_valid & chn_ready) != 0) begin
            if (eq[0].l) exp_pkt[eq[0].ch]++;
            void'(eq.pop_front());
          end
        end
      end
      if (s_valid && s_ready) void'(sq.pop_front());
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bad_chn) nbadseen++;
      chk("rnd_idle_cv", chn_valid, 0);
    end
    chk("rnd_sent_all", sq.size(), 0);
    chk("rnd_delivered_all", eq.size(), 0);
    chk("rnd_bad_count", nbadseen, nbad);
    chk_stats("rnd", nbad);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
